// File: rtl/controlador_pkg.sv
// Shared types and constants for the naval-battle turn sequencer.
package controlador_pkg;

  localparam int unsigned NUM_COLUNAS = 5;
  localparam int unsigned NUM_LINHAS  = 7;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CONTAGEM  = 3'd1,
    AGUARDA   = 3'd2,
    AVALIA    = 3'd3,
    RESULTADO = 3'd4,
    VITORIA   = 3'd5,
    DERROTA   = 3'd6
  } estado_t;

  typedef enum logic [1:0] {
    ACERTO,
    ERRO,
    REPETIDO
  } resultado_t;

  // An already revealed cell is a repeat even though it holds a ship.
  function automatic resultado_t classifica(input logic alvo, input logic revelado);
    if (revelado) return REPETIDO;
    if (alvo) return ACERTO;
    return ERRO;
  endfunction

endpackage

// File: rtl/controlador_de_partida_if.sv
// Link between the turn sequencer and the attack manager.
interface controlador_de_partida_if;

  logic       enable_ataque;
  logic       confirmar_ataque;
  logic [2:0] col_ataque;
  logic [2:0] lin_ataque;
  logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;

  modport master (
    output enable_ataque, confirmar_ataque, col_ataque, lin_ataque,
    input  matriz0, matriz1, matriz2, matriz3, matriz4
  );

  modport slave (
    input  enable_ataque, confirmar_ataque, col_ataque, lin_ataque,
    output matriz0, matriz1, matriz2, matriz3, matriz4
  );

endinterface

// File: rtl/detector_de_borda.sv
// Rising-edge detector; CONTROLADOR_SINCRONIZADOR_EN adds a two-flop synchronizer in front.
module detector_de_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic borda
);

  logic amostra;
  logic anterior_q;

`ifdef CONTROLADOR_SINCRONIZADOR_EN
  logic [1:0] sinc_q;

  always_ff @(posedge clock) begin
    if (reset) sinc_q <= '0;
    else       sinc_q <= {sinc_q[0], entrada};
  end

  assign amostra = sinc_q[1];
`else
  assign amostra = entrada;
`endif

  always_ff @(posedge clock) begin
    if (reset) anterior_q <= 1'b0;
    else       anterior_q <= amostra;
  end

  assign borda = amostra & ~anterior_q;

endmodule

// File: rtl/controlador_de_partida.sv
// Game FSM: counts targets, turns confirm presses into attack strobes, tracks lives and hits.
// Optional input synchronizers are enabled with CONTROLADOR_SINCRONIZADOR_EN.
module controlador_de_partida
  import controlador_pkg::*;
#(
  parameter int unsigned VIDAS_INICIAIS  = 3,
  parameter int unsigned TEMPO_RESULTADO = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  controlador_de_partida_if.master ataque,
  output logic [2:0] vida,
  output logic [5:0] acertos,
  output logic [5:0] alvos,
  output logic       LED_R,
  output logic       LED_G,
  output logic       vitoria,
  output logic       derrota,
  output logic [2:0] estado
);

  localparam int unsigned CntW = $clog2(TEMPO_RESULTADO + 1);
  localparam logic [CntW-1:0] HoldIni = CntW'(TEMPO_RESULTADO - 1);
  localparam logic [2:0] VidaIni = 3'(VIDAS_INICIAIS);
  localparam logic [2:0] UltCol  = 3'(NUM_COLUNAS - 1);
  localparam logic [2:0] UltLin  = 3'(NUM_LINHAS - 1);

  estado_t         state_q, state_d;
  logic            borda_iniciar, borda_confirmar;
  logic [2:0]      col_scan_q, col_scan_d, lin_scan_q, lin_scan_d;
  logic [2:0]      col_q, col_d, lin_q, lin_d;
  logic [2:0]      vida_q, vida_d;
  logic [5:0]      alvos_q, alvos_d, acertos_q, acertos_d;
  logic            led_r_q, led_r_d, led_g_q, led_g_d;
  logic            strobe_q, strobe_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  resultado_t      resultado;

  logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] mapa_w, matriz_w;

  assign mapa_w   = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign matriz_w = {ataque.matriz4, ataque.matriz3, ataque.matriz2, ataque.matriz1,
                     ataque.matriz0};

  detector_de_borda u_borda_iniciar (
    .clock   (clock),
    .reset   (reset),
    .entrada (iniciar),
    .borda   (borda_iniciar)
  );

  detector_de_borda u_borda_confirmar (
    .clock   (clock),
    .reset   (reset),
    .entrada (confirmar),
    .borda   (borda_confirmar)
  );

  assign resultado = classifica(mapa_w[col_q][lin_q], matriz_w[col_q][lin_q]);

  always_comb begin
    state_d    = state_q;
    col_scan_d = col_scan_q;
    lin_scan_d = lin_scan_q;
    col_d      = col_q;
    lin_d      = lin_q;
    vida_d     = vida_q;
    alvos_d    = alvos_q;
    acertos_d  = acertos_q;
    led_r_d    = led_r_q;
    led_g_d    = led_g_q;
    strobe_d   = 1'b0;
    cnt_d      = cnt_q;

    case (state_q)
      OCIOSO, VITORIA, DERROTA: begin
        if (borda_iniciar) begin
          acertos_d  = '0;
          alvos_d    = '0;
          led_r_d    = 1'b0;
          led_g_d    = 1'b0;
          vida_d     = VidaIni;
          col_scan_d = '0;
          lin_scan_d = '0;
          state_d    = CONTAGEM;
        end
      end
      CONTAGEM: begin
        alvos_d = alvos_q + {5'd0, mapa_w[col_scan_q][lin_scan_q]};
        if (lin_scan_q == UltLin) begin
          lin_scan_d = '0;
          if (col_scan_q == UltCol) state_d = (alvos_d == '0) ? VITORIA : AGUARDA;
          else                      col_scan_d = col_scan_q + 3'd1;
        end else begin
          lin_scan_d = lin_scan_q + 3'd1;
        end
      end
      AGUARDA: begin
        if (borda_confirmar && coordColuna <= UltCol && coordLinha <= UltLin) begin
          col_d   = coordColuna;
          lin_d   = coordLinha;
          state_d = AVALIA;
        end
      end
      AVALIA: begin
        unique case (resultado)
          REPETIDO: begin
            led_r_d = 1'b1;
            led_g_d = 1'b1;
          end
          ACERTO: begin
            strobe_d  = 1'b1;
            acertos_d = acertos_q + 6'd1;
            led_r_d   = 1'b0;
            led_g_d   = 1'b1;
          end
          ERRO: begin
            strobe_d = 1'b1;
            vida_d   = (vida_q == '0) ? '0 : vida_q - 3'd1;
            led_r_d  = 1'b1;
            led_g_d  = 1'b0;
          end
          default: ;
        endcase
        cnt_d   = HoldIni;
        state_d = RESULTADO;
      end
      RESULTADO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (acertos_q == alvos_q) begin
          state_d = VITORIA;
        end else if (vida_q == '0) begin
          state_d = DERROTA;
        end else begin
          led_r_d = 1'b0;
          led_g_d = 1'b0;
          state_d = AGUARDA;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= OCIOSO;
      col_scan_q <= '0;
      lin_scan_q <= '0;
      col_q      <= '0;
      lin_q      <= '0;
      vida_q     <= VidaIni;
      alvos_q    <= '0;
      acertos_q  <= '0;
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      strobe_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_scan_q <= col_scan_d;
      lin_scan_q <= lin_scan_d;
      col_q      <= col_d;
      lin_q      <= lin_d;
      vida_q     <= vida_d;
      alvos_q    <= alvos_d;
      acertos_q  <= acertos_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      strobe_q   <= strobe_d;
      cnt_q      <= cnt_d;
    end
  end

  // The attack manager must stay enabled after the game ends so the board remains visible.
  assign ataque.enable_ataque    = (state_q != OCIOSO) && (state_q != CONTAGEM);
  assign ataque.confirmar_ataque = strobe_q;
  assign ataque.col_ataque       = col_q;
  assign ataque.lin_ataque       = lin_q;

  assign vida    = vida_q;
  assign acertos = acertos_q;
  assign alvos   = alvos_q;
  assign LED_R   = led_r_q;
  assign LED_G   = led_g_q;
  assign vitoria = (state_q == VITORIA);
  assign derrota = (state_q == DERROTA);
  assign estado  = state_q;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Self-checking bench for controlador_de_partida with a behavioural attack-manager model.
module tb_controlador_de_partida;
  import controlador_pkg::*;

  logic       clock = 1'b0;
  logic       reset, iniciar, confirmar;
  logic [2:0] coordColuna, coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [2:0] vida, estado;
  logic [5:0] acertos, alvos;
  logic       LED_R, LED_G, vitoria, derrota;

  controlador_de_partida_if bus ();

  controlador_de_partida #(
    .VIDAS_INICIAIS  (3),
    .TEMPO_RESULTADO (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .confirmar   (confirmar),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .mapa0       (mapa0),
    .mapa1       (mapa1),
    .mapa2       (mapa2),
    .mapa3       (mapa3),
    .mapa4       (mapa4),
    .ataque      (bus),
    .vida        (vida),
    .acertos     (acertos),
    .alvos       (alvos),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .vitoria     (vitoria),
    .derrota     (derrota),
    .estado      (estado)
  );

  always #5 clock = ~clock;

  logic [6:0] mapa_tb [5];
  logic [6:0] mat [5];
  logic [6:0] atingido [5];

  assign mapa0 = mapa_tb[0];
  assign mapa1 = mapa_tb[1];
  assign mapa2 = mapa_tb[2];
  assign mapa3 = mapa_tb[3];
  assign mapa4 = mapa_tb[4];
  assign bus.matriz0 = mat[0];
  assign bus.matriz1 = mat[1];
  assign bus.matriz2 = mat[2];
  assign bus.matriz3 = mat[3];
  assign bus.matriz4 = mat[4];

  // Attack manager: cleared while disabled, reveals a ship cell when it is struck.
  always @(posedge clock) begin
    if (reset || !bus.enable_ataque) begin
      for (int i = 0; i < 5; i++) mat[i] <= '0;
    end else if (bus.confirmar_ataque && mapa_tb[bus.col_ataque][bus.lin_ataque]) begin
      mat[bus.col_ataque][bus.lin_ataque] <= 1'b1;
    end
  end

  typedef struct {
    logic       strobe;
    logic       led_r;
    logic       led_g;
    logic [2:0] vida;
    logic [5:0] acertos;
    estado_t    prox;
  } esperado_t;

  esperado_t fila[$];
  int n_checks = 0;
  int n_fail = 0;
  int vida_m, acertos_m;

  task automatic test_reset;
    reset = 1'b1; iniciar = 1'b0; confirmar = 1'b0; coordColuna = '0; coordLinha = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (estado !== OCIOSO) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", estado); end
    n_checks++; if (vida !== 3'd3) begin n_fail++; $display("FAIL reset_vida: got %0d want 3", vida); end
    n_checks++; if ({acertos, alvos} !== 12'd0) begin n_fail++; $display("FAIL reset_contadores: got %0d/%0d want 0/0", acertos, alvos); end
    n_checks++; if ({bus.enable_ataque, bus.confirmar_ataque, LED_R, LED_G, vitoria, derrota} !== 6'd0) begin
      n_fail++; $display("FAIL reset_saidas: got %b want 000000",
                         {bus.enable_ataque, bus.confirmar_ataque, LED_R, LED_G, vitoria, derrota}); end
    n_checks++; if ({bus.col_ataque, bus.lin_ataque} !== 6'd0) begin n_fail++; $display("FAIL reset_coord: got %0d,%0d want 0,0", bus.col_ataque, bus.lin_ataque); end
    reset = 1'b0;
  endtask

  task automatic test_start;
    int n;
    vida_m = 3; acertos_m = 0;
    for (int i = 0; i < 5; i++) atingido[i] = '0;
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    n_checks++; if (bus.enable_ataque !== 1'b0) begin n_fail++; $display("FAIL start_enable_baixo: got %b want 0", bus.enable_ataque); end
    n = 0;
    while (estado === CONTAGEM && n < 40) begin n++; @(negedge clock); end
    n_checks++; if (n !== 35) begin n_fail++; $display("FAIL start_ciclos_contagem: got %0d want 35", n); end
    n_checks++; if (estado !== AGUARDA) begin n_fail++; $display("FAIL start_estado: got %0d want 2", estado); end
    n_checks++; if (alvos !== 6'd8) begin n_fail++; $display("FAIL start_alvos: got %0d want 8", alvos); end
    n_checks++; if (vida !== 3'd3 || acertos !== 6'd0) begin n_fail++; $display("FAIL start_vida_acertos: got %0d/%0d want 3/0", vida, acertos); end
    n_checks++; if (bus.enable_ataque !== 1'b1) begin n_fail++; $display("FAIL start_enable_alto: got %b want 1", bus.enable_ataque); end
  endtask

  task automatic ataque(input int c, input int r, input bit conf_no_hold);
    esperado_t e, o;
    if (atingido[c][r]) begin
      e.strobe = 1'b0; e.led_r = 1'b1; e.led_g = 1'b1;
    end else if (mapa_tb[c][r]) begin
      e.strobe = 1'b1; e.led_r = 1'b0; e.led_g = 1'b1;
      acertos_m++; atingido[c][r] = 1'b1;
    end else begin
      e.strobe = 1'b1; e.led_r = 1'b1; e.led_g = 1'b0;
      if (vida_m > 0) vida_m--;
    end
    e.vida = 3'(vida_m); e.acertos = 6'(acertos_m);
    e.prox = (acertos_m == 8) ? VITORIA : (vida_m == 0) ? DERROTA : AGUARDA;
    fila.push_back(e);
    @(negedge clock); coordColuna = 3'(c); coordLinha = 3'(r); confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0; coordColuna = 3'd7; coordLinha = 3'd7;
    n_checks++; if (estado !== AVALIA || bus.confirmar_ataque !== 1'b0) begin n_fail++; $display("FAIL avalia_k1 (%0d,%0d): got estado %0d strobe %b want 3/0", c, r, estado, bus.confirmar_ataque); end
    n_checks++; if (bus.col_ataque !== 3'(c) || bus.lin_ataque !== 3'(r)) begin n_fail++; $display("FAIL coord_latch (%0d,%0d): got %0d,%0d", c, r, bus.col_ataque, bus.lin_ataque); end
    @(negedge clock);
    o = fila.pop_front();
    n_checks++; if (bus.confirmar_ataque !== o.strobe) begin n_fail++; $display("FAIL strobe_k2 (%0d,%0d): got %b want %b", c, r, bus.confirmar_ataque, o.strobe); end
    n_checks++; if (vida !== o.vida || acertos !== o.acertos) begin n_fail++; $display("FAIL contadores (%0d,%0d): got vida %0d acertos %0d want %0d %0d", c, r, vida, acertos, o.vida, o.acertos); end
    n_checks++; if (LED_R !== o.led_r || LED_G !== o.led_g) begin n_fail++; $display("FAIL leds (%0d,%0d): got R%b G%b want R%b G%b", c, r, LED_R, LED_G, o.led_r, o.led_g); end
    n_checks++; if (bus.col_ataque !== 3'(c) || bus.lin_ataque !== 3'(r)) begin n_fail++; $display("FAIL coord_estavel (%0d,%0d): got %0d,%0d", c, r, bus.col_ataque, bus.lin_ataque); end
    @(negedge clock);
    if (conf_no_hold) begin coordColuna = 3'd1; coordLinha = 3'd1; confirmar = 1'b1; end
    n_checks++; if (bus.confirmar_ataque !== 1'b0) begin n_fail++; $display("FAIL strobe_unico (%0d,%0d): got 1 want 0", c, r); end
    repeat (2) begin
      @(negedge clock); confirmar = 1'b0;
      n_checks++; if (estado !== RESULTADO || bus.confirmar_ataque !== 1'b0) begin n_fail++; $display("FAIL hold (%0d,%0d): got estado %0d strobe %b want 4/0", c, r, estado, bus.confirmar_ataque); end
    end
    @(negedge clock);
    n_checks++; if (estado !== o.prox) begin n_fail++; $display("FAIL prox_estado (%0d,%0d): got %0d want %0d", c, r, estado, o.prox); end
    if (o.prox == AGUARDA) begin
      n_checks++; if (LED_R !== 1'b0 || LED_G !== 1'b0) begin n_fail++; $display("FAIL leds_limpos: got R%b G%b want 0 0", LED_R, LED_G); end
    end
  endtask

  task automatic test_hit;
    ataque(0, 0, 1'b0);
  endtask

  task automatic test_repeat_invalid;
    ataque(0, 0, 1'b0);
    @(negedge clock); coordColuna = 3'd5; coordLinha = 3'd2; confirmar = 1'b1; iniciar = 1'b1;
    @(negedge clock); confirmar = 1'b0; iniciar = 1'b0;
    repeat (3) begin
      n_checks++; if (estado !== AGUARDA || bus.confirmar_ataque !== 1'b0) begin n_fail++; $display("FAIL invalido: got estado %0d strobe %b want 2/0", estado, bus.confirmar_ataque); end
      @(negedge clock);
    end
  endtask

  task automatic test_defeat;
    for (int i = 0; i < 3; i++) ataque(2, 3, 1'b0);
    n_checks++; if (derrota !== 1'b1 || vitoria !== 1'b0 || bus.enable_ataque !== 1'b1) begin n_fail++; $display("FAIL derrota_flags: got d%b v%b en%b want 1 0 1", derrota, vitoria, bus.enable_ataque); end
    test_start;
  endtask

  task automatic test_victory;
    ataque(0, 0, 1'b0);
    ataque(0, 4, 1'b0);
    ataque(0, 5, 1'b1);
    ataque(0, 6, 1'b0);
    ataque(1, 5, 1'b0);
    ataque(4, 4, 1'b0);
    ataque(4, 5, 1'b1);
    ataque(4, 6, 1'b0);
    n_checks++; if (vitoria !== 1'b1 || derrota !== 1'b0 || bus.enable_ataque !== 1'b1) begin n_fail++; $display("FAIL vitoria_flags: got v%b d%b en%b want 1 0 1", vitoria, derrota, bus.enable_ataque); end
  endtask

  task automatic test_reset_mid;
    test_start;
    @(negedge clock); coordColuna = 3'd2; coordLinha = 3'd0; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_checks++; if (estado !== OCIOSO || vida !== 3'd3 || acertos !== 6'd0) begin n_fail++; $display("FAIL reset_resultado: got estado %0d vida %0d acertos %0d want 0 3 0", estado, vida, acertos); end
    n_checks++; if ({LED_R, LED_G, vitoria, derrota, bus.enable_ataque} !== 5'd0) begin n_fail++; $display("FAIL reset_resultado_saidas: got %b want 00000", {LED_R, LED_G, vitoria, derrota, bus.enable_ataque}); end
    test_start;
    @(negedge clock); coordColuna = 3'd0; coordLinha = 3'd4; confirmar = 1'b1;
    @(negedge clock); confirmar = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    n_checks++; if (bus.confirmar_ataque !== 1'b0 || estado !== OCIOSO || acertos !== 6'd0) begin n_fail++; $display("FAIL reset_strobe: got strobe %b estado %0d acertos %0d want 0 0 0", bus.confirmar_ataque, estado, acertos); end
  endtask

  initial begin
    mapa_tb[0] = 7'b1110001;
    mapa_tb[1] = 7'b0100000;
    mapa_tb[2] = 7'b0000000;
    mapa_tb[3] = 7'b0000000;
    mapa_tb[4] = 7'b1110000;
    test_reset;
    test_start;
    test_hit;
    test_repeat_invalid;
    test_defeat;
    test_victory;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
